// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver
// Description : Start-bit framed serial receiver with a first-word-fall-through
//               frame FIFO, sticky overflow flag and enforced inter-frame idle.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver #(
    parameter int DATA_BITS = 40,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 0,
    parameter int IDLE_MIN  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     si,
    output logic [DATA_BITS-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(DATA_BITS - 1);
    localparam logic [7:0]         c_IDLE_LAST = 8'(IDLE_MIN - 1);
    localparam logic [c_AW:0]      c_FULL_LVL  = (c_AW + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_PUSH  = 2'd2;
    localparam logic [1:0] c_ST_REARM = 2'd3;

    logic [1:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [7:0]           r_idle_cnt;
    logic                 r_ovf;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_level;
    logic [DATA_BITS-1:0] r_hold;

    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_wr;
    logic                 w_drop;

    always_comb begin
        w_shift_next = r_shift;
        if (LSB_FIRST != 0) begin
            w_shift_next                = r_shift >> 1;
            w_shift_next[DATA_BITS-1]   = si;
        end else begin
            w_shift_next    = r_shift << 1;
            w_shift_next[0] = si;
        end
    end

    assign w_full = (r_level == c_FULL_LVL);
    assign w_pop  = out_valid && out_ready;
    assign w_push = (r_state == c_ST_PUSH);
    // A pop in the same cycle frees the slot the completed frame needs.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (si) begin
                        r_state   <= c_ST_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_SHIFT: begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_state <= c_ST_PUSH;
                    end
                end
                c_ST_PUSH: begin
                    r_state    <= c_ST_REARM;
                    r_idle_cnt <= '0;
                end
                c_ST_REARM: begin
                    if (si) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == c_IDLE_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (c_AW + 1)'(1);
                2'b01:   r_level <= r_level - (c_AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // When empty, the last popped frame stays visible instead of a stale slot.
    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : r_hold;
    assign level     = r_level;
    assign busy      = (r_state != c_ST_IDLE);
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_receiver
// Description : Directed self-checking bench for serial_frame_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        si;
    logic        out_ready;
    logic        ovf_clr;
    logic [39:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic        busy;
    logic        overflow;

    logic        si8;
    logic        rdy8;
    logic        clr8;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_busy, b_busy, a_ovf, b_ovf;
    logic [2:0]  a_level, b_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_frame_receiver #(.DATA_BITS(40), .DEPTH(4), .LSB_FIRST(0), .IDLE_MIN(1)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    serial_frame_receiver #(.DATA_BITS(8), .DEPTH(2), .LSB_FIRST(1), .IDLE_MIN(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .si(si8), .out_data(a_data), .out_valid(a_valid),
        .out_ready(rdy8), .level(a_level[1:0]), .busy(a_busy), .overflow(a_ovf), .ovf_clr(clr8)
    );

    serial_frame_receiver #(.DATA_BITS(8), .DEPTH(2), .LSB_FIRST(0), .IDLE_MIN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .si(si8), .out_data(b_data), .out_valid(b_valid),
        .out_ready(rdy8), .level(b_level[1:0]), .busy(b_busy), .overflow(b_ovf), .ovf_clr(clr8)
    );

    assign a_level[2] = 1'b0;
    assign b_level[2] = 1'b0;

    typedef struct {
        logic [39:0] frame;
        logic [2:0]  exp_level;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge just before the PUSH edge.
    task automatic send40(input logic [39:0] d);
        @(negedge clk);
        si = 1'b1;
        for (int i = 39; i >= 0; i--) begin
            @(negedge clk);
            si = d[i];
        end
        @(negedge clk);
        si = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d);
        @(negedge clk);
        si8 = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            si8 = d[i];
        end
        @(negedge clk);
        si8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] exp6 [4];

        tbl[0] = '{40'h0123456789, 3'd1, 1'b0};
        tbl[1] = '{40'hFEDCBA9876, 3'd2, 1'b0};
        tbl[2] = '{40'h5A5A5A5A5A, 3'd3, 1'b0};
        tbl[3] = '{40'h8000000001, 3'd4, 1'b0};
        tbl[4] = '{40'hC3C3C3C3C3, 3'd4, 1'b1};

        rst_n = 1'b0; si = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        si8 = 1'b0; rdy8 = 1'b0; clr8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        // Single default frame, latency and pop
        send40(40'hA9F0AAAAA9);
        check("push_busy", busy, 1);
        check("valid_before_write", out_valid, 0);
        @(negedge clk);
        check("valid_after_write", out_valid, 1);
        check("level_one", level, 1);
        check("frame_data", out_data, 40'hA9F0AAAAA9);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pop_level", level, 0);
        check("pop_valid", out_valid, 0);
        check("hold_data", out_data, 40'hA9F0AAAAA9);
        check("idle_busy", busy, 0);

        // Back-to-back minimum-gap frames into a full FIFO
        for (int k = 0; k < 5; k++) begin
            send40(tbl[k].frame);
            @(negedge clk);
            check($sformatf("tbl_level_%0d", k), level, tbl[k].exp_level);
            check($sformatf("tbl_ovf_%0d", k), overflow, tbl[k].exp_ovf);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tbl_pop_data_%0d", k), out_data, tbl[k].frame);
            check($sformatf("tbl_pop_valid_%0d", k), out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("drained_level", level, 0);

        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Drop coinciding with ovf_clr: set wins
        for (int k = 0; k < 4; k++) begin
            send40(tbl[k].frame);
            @(negedge clk);
        end
        send40(tbl[4].frame);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_set_wins", overflow, 1);
        check("full_level", level, 4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared2", overflow, 0);

        // Full FIFO with a pop on the PUSH edge accepts the frame
        send40(40'h1122334455);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("push_pop_level", level, 4);
        check("push_pop_ovf", overflow, 0);
        exp6[0] = tbl[1].frame; exp6[1] = tbl[2].frame;
        exp6[2] = tbl[3].frame; exp6[3] = 40'h1122334455;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("push_pop_data_%0d", k), out_data, exp6[k]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("push_pop_drained", level, 0);

        // si held high during REARM must not start a frame
        send40(40'h0F0F0F0F0F);
        @(negedge clk);
        si = 1'b1;
        repeat (5) @(negedge clk);
        check("rearm_busy", busy, 1);
        si = 1'b0;
        @(negedge clk);
        check("rearm_done", busy, 0);
        send40(40'hDEADBEEF01);
        @(negedge clk);
        check("rearm_level", level, 2);
        check("rearm_head", out_data, 40'h0F0F0F0F0F);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rearm_second", out_data, 40'hDEADBEEF01);
        send40(40'h2468ACE135);
        @(negedge clk);
        check("pre_reset_level", level, 2);

        // Reset in the middle of a frame
        @(negedge clk);
        si = 1'b1;
        for (int i = 39; i >= 20; i--) begin
            @(negedge clk);
            si = ~si;
        end
        check("mid_frame_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        si = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_data", out_data, 0);
        check("mrst_level", level, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send40(40'h13579BDF02);
        @(negedge clk);
        check("post_reset_level", level, 1);
        check("post_reset_data", out_data, 40'h13579BDF02);

        // Bit order and IDLE_MIN on the 8-bit instances
        send8(8'b1000_0000);
        @(negedge clk);
        check("lsb_first_data", a_data, 8'h01);
        check("msb_first_data", b_data, 8'h80);
        @(negedge clk);
        @(negedge clk);
        check("idle3_still_busy", a_busy, 1);
        check("idle1_done", b_busy, 0);
        @(negedge clk);
        check("idle3_done", a_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
